// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants and buffer type for the four-digit multiplexed seven-segment scanner.
package seg7_scan_driver_pkg;

   localparam int NUM_DIGITS          = 4;
   localparam int DIGIT_IDX_W         = 2;
   localparam int CODE_W              = 4;
   localparam int VALUE_W             = NUM_DIGITS * CODE_W;
   localparam int REFRESH_DIV_DEFAULT = 50000;

   // One displayable frame: four codes plus one decimal point per digit.
   typedef struct packed {
      logic [VALUE_W-1:0]    value;
      logic [NUM_DIGITS-1:0] dots;
   } disp_buf_t;

endpackage

// File: rtl/seg7_scan_driver_refresh_prescaler.sv
// Free-running divider; TICK_OUT marks the last cycle of every DIV-cycle digit slot.
module refresh_prescaler
   import seg7_scan_driver_pkg::*;
#(
   parameter int DIV = REFRESH_DIV_DEFAULT
) (
   input  logic CLK,
   input  logic RESET,
   output logic TICK_OUT
);

   localparam int              CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

   assign TICK_OUT = (count == LAST);

endmodule

// File: rtl/seg7_scan_driver.sv
// Scans four digits round-robin; new values are double-buffered and only swapped in at a frame boundary.
module seg7_scan_driver
   import seg7_scan_driver_pkg::*;
#(
   parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [VALUE_W-1:0]     VALUE_IN,
   input  logic [NUM_DIGITS-1:0]  DOT_MASK_IN,
   input  logic                   LOAD_IN,
   output logic [DIGIT_IDX_W-1:0] SEG_SELECT_OUT,
   output logic [CODE_W-1:0]      BIN_OUT,
   output logic                   DOT_OUT,
   output logic                   PENDING_OUT,
   output logic                   FRAME_TICK_OUT
);

   localparam logic [DIGIT_IDX_W-1:0] LAST_IDX = DIGIT_IDX_W'(NUM_DIGITS - 1);

   logic                   slot_tick;
   logic                   wrap;
   logic                   commit;
   logic [DIGIT_IDX_W-1:0] digit_idx;
   logic                   pending;
   logic                   frame_tick;
   disp_buf_t              active_buf;
   disp_buf_t              pending_buf;

   refresh_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
      .CLK      (CLK),
      .RESET    (RESET),
      .TICK_OUT (slot_tick)
   );

   assign wrap   = slot_tick && (digit_idx == LAST_IDX);
   assign commit = wrap && pending;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         digit_idx  <= '0;
         frame_tick <= 1'b0;
      end else begin
         if (slot_tick) begin
            digit_idx <= digit_idx + DIGIT_IDX_W'(1);
         end
         frame_tick <= wrap;
      end
   end

   // A load on the commit edge still lets the older pending frame through; the new one stays pending.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         active_buf  <= '0;
         pending_buf <= '0;
         pending     <= 1'b0;
      end else begin
         if (commit) begin
            active_buf <= pending_buf;
         end
         if (LOAD_IN) begin
            pending_buf.value <= VALUE_IN;
            pending_buf.dots  <= DOT_MASK_IN;
            pending           <= 1'b1;
         end else if (commit) begin
            pending <= 1'b0;
         end
      end
   end

   assign SEG_SELECT_OUT = digit_idx;
   assign BIN_OUT        = active_buf.value[digit_idx*CODE_W +: CODE_W];
   assign DOT_OUT        = active_buf.dots[digit_idx];
   assign PENDING_OUT    = pending;
   assign FRAME_TICK_OUT = frame_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: cycle-count reference model per build plus directed frame checks.
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] value_in = '0;
   logic [3:0]  dot_in = '0;
   logic        load_in = 1'b0;
   bit          check_en = 1'b0;

   logic [1:0] sel  [2];
   logic [3:0] bin  [2];
   logic       dot  [2];
   logic       pend [2];
   logic       ft   [2];

   int n_checks = 0;
   int n_pass   = 0;
   logic [4:0] exp_q[$];

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
   endtask

   // Two builds share stimulus: slot length 4 (directed target) and slot length 2.
   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int DIV = (g == 0) ? 4 : 2;

      seg7_scan_driver #(.REFRESH_DIV(DIV)) u_dut (
         .CLK            (clk),
         .RESET          (rst),
         .VALUE_IN       (value_in),
         .DOT_MASK_IN    (dot_in),
         .LOAD_IN        (load_in),
         .SEG_SELECT_OUT (sel[g]),
         .BIN_OUT        (bin[g]),
         .DOT_OUT        (dot[g]),
         .PENDING_OUT    (pend[g]),
         .FRAME_TICK_OUT (ft[g])
      );

      // Model: n = cycles since reset; digit = (n / DIV) mod 4; a frame ends every 4*DIV cycles.
      int          n = 0;
      logic [15:0] a_val = '0, p_val = '0;
      logic [3:0]  a_dot = '0, p_dot = '0;
      bit          m_pend = 1'b0, m_ft = 1'b0, frame_end;

      always @(posedge clk) begin
         if (rst) begin
            n = 0; a_val = '0; a_dot = '0; p_val = '0; p_dot = '0;
            m_pend = 1'b0; m_ft = 1'b0;
         end else begin
            frame_end = (n % (4 * DIV)) == (4 * DIV - 1);
            if (frame_end && m_pend) begin
               a_val = p_val;
               a_dot = p_dot;
            end
            if (load_in) begin
               p_val = value_in; p_dot = dot_in; m_pend = 1'b1;
            end else if (frame_end) begin
               m_pend = 1'b0;
            end
            m_ft = frame_end;
            n++;
         end
      end

      always @(negedge clk) begin
         if (check_en) begin
            int idx;
            idx = (n / DIV) % 4;
            check($sformatf("div%0d_sel", DIV), 32'(sel[g]), 32'(idx));
            check($sformatf("div%0d_bin", DIV), 32'(bin[g]), 32'((a_val >> (4 * idx)) & 16'hF));
            check($sformatf("div%0d_dot", DIV), 32'(dot[g]), 32'(a_dot[idx]));
            check($sformatf("div%0d_pend", DIV), 32'(pend[g]), 32'(m_pend));
            check($sformatf("div%0d_ft", DIV), 32'(ft[g]), 32'(m_ft));
         end
      end
   end

   task automatic tick(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic load(input logic [15:0] v, input logic [3:0] d);
      value_in = v; dot_in = d; load_in = 1'b1;
      @(negedge clk);
      load_in = 1'b0;
   endtask

   task automatic wait_ft();
      bit ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (ft[0] === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      check("wait_frame_tick", 32'(ok), 32'd1);
   endtask

   task automatic wait_sel(input logic [1:0] v);
      bit ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (sel[0] === v) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      check("wait_sel", 32'(ok), 32'd1);
   endtask

   // Called on a frame-tick cycle: checks {dot,bin} of four consecutive slots against exp_q.
   task automatic check_frame(input string name);
      for (int s = 0; s < 4; s++) begin
         check({name, "_sel"}, 32'(sel[0]), 32'(s));
         check(name, 32'({dot[0], bin[0]}), 32'(exp_q.pop_front()));
         tick(4);
      end
   endtask

   initial begin
      int cyc;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_en = 1'b1;
      check("rst_sel", 32'(sel[0]), 32'd0);
      check("rst_bin", 32'(bin[0]), 32'd0);
      check("rst_pend", 32'(pend[0]), 32'd0);
      check("rst_ft", 32'(ft[0]), 32'd0);
      rst = 1'b0;

      // Idle scan: first frame tick 16 cycles after reset release.
      cyc = 0;
      while (ft[0] !== 1'b1 && cyc < 64) begin tick(1); cyc++; end
      check("first_frame_cycles", 32'(cyc), 32'd16);

      // Load during digit 1; held until the frame boundary.
      wait_sel(2'd1);
      load(16'h1234, 4'b0100);
      check("pend_after_load", 32'(pend[0]), 32'd1);
      check("bin_before_commit", 32'(bin[0]), 32'd0);
      wait_ft();
      exp_q.push_back(5'h04); exp_q.push_back(5'h03);
      exp_q.push_back(5'h12); exp_q.push_back(5'h01);
      check_frame("frame_1234");
      check("pend_after_commit", 32'(pend[0]), 32'd0);

      // Two loads in one frame: the later one wins.
      load(16'hAAAA, 4'b1000);
      load(16'h5555, 4'b0011);
      wait_ft();
      exp_q.push_back(5'h15); exp_q.push_back(5'h15);
      exp_q.push_back(5'h05); exp_q.push_back(5'h05);
      check_frame("frame_5555");

      // Load on the exact commit edge with 1111 already pending.
      load(16'h1111, 4'b0000);
      tick(14);
      load(16'h00FF, 4'b0001);
      check("n1_ft", 32'(ft[0]), 32'd1);
      check("n1_bin", 32'(bin[0]), 32'd1);
      check("n1_pend", 32'(pend[0]), 32'd1);
      tick(16);
      check("n2_ft", 32'(ft[0]), 32'd1);
      check("n2_bin", 32'(bin[0]), 32'hF);
      check("n2_dot", 32'(dot[0]), 32'd1);
      check("n2_pend", 32'(pend[0]), 32'd0);

      // LOAD_IN held for three cycles: last sample wins.
      value_in = 16'hABCD; dot_in = 4'b1111; load_in = 1'b1;
      tick(1);
      value_in = 16'h0001;
      tick(1);
      value_in = 16'h9876; dot_in = 4'b0110;
      tick(1);
      load_in = 1'b0;
      wait_ft();
      exp_q.push_back(5'h06); exp_q.push_back(5'h17);
      exp_q.push_back(5'h18); exp_q.push_back(5'h09);
      check_frame("frame_9876");

      // Reset mid-frame with a value pending.
      load(16'hDEAD, 4'b1111);
      wait_sel(2'd2);
      tick(1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("mrst_sel", 32'(sel[0]), 32'd0);
      check("mrst_bin", 32'(bin[0]), 32'd0);
      check("mrst_dot", 32'(dot[0]), 32'd0);
      check("mrst_pend", 32'(pend[0]), 32'd0);
      check("mrst_ft", 32'(ft[0]), 32'd0);
      cyc = 0;
      while (sel[0] === 2'd0 && cyc < 32) begin tick(1); cyc++; end
      check("slot_after_reset", 32'(cyc), 32'd4);
      wait_ft();
      check("post_rst_frame_bin", 32'(bin[0]), 32'd0);
      check("post_rst_frame_pend", 32'(pend[0]), 32'd0);

      tick(20);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clock cycles per digit slot; legal range 2..2^20.
REQ-002 CLK  input  1  single system clock; all state changes on rising edge.
REQ-003 RESET  input  1  reset, synchronous and active-high.
REQ-004 VALUE_IN  input  16  four 4-bit codes; [3:0] rightmost digit 0 ... [15:12] leftmost digit 3.
REQ-005 DOT_MASK_IN  input  4  decimal-point request per digit; bit n applies to digit n.
REQ-006 LOAD_IN  input  1  one-cycle strobe; captures VALUE_IN and DOT_MASK_IN into the pending buffer.
REQ-007 SEG_SELECT_OUT  output  2  current digit index, feeds the downstream decoder select input.
REQ-008 BIN_OUT  output  4  code of the current digit, feeds the downstream decoder data input.
REQ-009 DOT_OUT  output  1  decimal-point bit of the current digit (1 = dot lit).
REQ-010 PENDING_OUT  output  1  high while a loaded value waits for commit.
REQ-011 FRAME_TICK_OUT  output  1  one-cycle pulse when the digit index wraps from 3 to 0.

Function
REQ-012 Prescaler counts 0..REFRESH_DIV-1 and wraps; slot tick asserts internally for the one cycle in which the count equals REFRESH_DIV-1.
REQ-013 On each slot tick, the digit index increments modulo 4; otherwise it holds.
REQ-014 The active buffer is 16-bit value plus 4-bit dot mask; it changes only at commit or reset.
REQ-015 LOAD_IN high: pending buffer takes VALUE_IN and DOT_MASK_IN on that edge; PENDING_OUT high from the next cycle.
REQ-016 Back-to-back loads before commit: last load wins; earlier pending contents are discarded.
REQ-017 Commit occurs on the slot tick where the index goes 3 -> 0 while PENDING_OUT is high: active takes pending; PENDING_OUT clears.
REQ-018 LOAD_IN coinciding with a commit tick: commit transfers the old pending contents; the new load becomes pending; PENDING_OUT stays high.
REQ-019 Commit never occurs mid-frame; a new value first appears on digit 0, so no frame mixes old and new digits.
REQ-020 SEG_SELECT_OUT equals the digit index register; BIN_OUT equals active value nibble [4*idx+3:4*idx]; DOT_OUT equals active dot mask bit [idx]; all three are driven from registers through a mux only, with no extra latency.
REQ-021 FRAME_TICK_OUT is registered and high for exactly the one cycle in which the index reads 0 after a 3 -> 0 wrap.
REQ-022 Digit slot length is exactly REFRESH_DIV cycles. Frame length is exactly 4*REFRESH_DIV cycles.
REQ-023 LOAD_IN held high for several cycles acts as repeated loads; per REQ-016 the last captured sample wins.

Reset
REQ-024 While RESET is high, all of the following are zero: prescaler, digit index, active buffer, pending buffer and pending flag.
REQ-025 During and after reset, outputs are SEG_SELECT_OUT=0, BIN_OUT=0, DOT_OUT=0, PENDING_OUT=0, FRAME_TICK_OUT=0.
REQ-026 RESET has priority over LOAD_IN and tick; reset mid-frame discards the pending value, and scanning restarts at digit 0 with a full slot.

Structure
REQ-027 Shared package holds NUM_DIGITS=4, DIGIT_IDX_W=2, CODE_W=4 and the default REFRESH_DIV.
REQ-028 The prescaler is sub-module refresh_prescaler (parameter DIV; ports CLK, RESET, TICK_OUT). Buffers, index and output mux stay in seg7_scan_driver.
REQ-029 No combinational path from LOAD_IN or VALUE_IN to any output.

Verification (REFRESH_DIV=4 unless stated)
REQ-030 Reset release, no load: SEG_SELECT_OUT sequence 0,1,2,3,0 with 4 cycles per value; BIN_OUT=0 and DOT_OUT=0 throughout; FRAME_TICK_OUT pulses every 16 cycles.
REQ-031 LOAD_IN with VALUE_IN=16'h1234 and DOT_MASK_IN=4'b0100 at digit 1: PENDING_OUT=1 until the next 3->0 wrap. Display stays 0 until then. The next frame shows BIN_OUT 4,3,2,1 for idx 0..3, with DOT_OUT=1 only at idx 2.
REQ-032 Two loads, 16'hAAAA then 16'h5555, in the same frame: only 5555 is committed; AAAA never appears on BIN_OUT.
REQ-033 LOAD 16'h00FF on the exact commit tick with 16'h1111 pending: frame n+1 shows 1111 with PENDING_OUT=1; frame n+2 shows 00FF with PENDING_OUT=0.
REQ-034 RESET pulse at digit 2 with a value pending: outputs return to zero, PENDING_OUT=0, and the scan restarts at digit 0 with a full 4-cycle slot.
REQ-035 REFRESH_DIV=2 build: each digit is held exactly 2 cycles; the commit rule of REQ-017 is unchanged.
